piso_serializer: RTL and testbench

//   Parallel-in serial-out stage feeding the sipo deserializer: accepts a WIDTH-bit word over a

---
 rtl/piso_pkg.sv | 22 ++
 rtl/piso_bit_cnt.sv | 31 +++
 rtl/piso_serializer.sv | 136 +++++++++++++
 tb/tb_piso_serializer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_serializer block: FSM state encoding,
// counter width helper and the even-parity function.
package piso_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_GAP    = 2'd3
  } state_e;

  // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Even parity of a word zero-extended to 64 bits.
  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Clearable up-counter with a terminal-count flag at LAST; used for both the
// frame bit position and the inter-frame gap length.
module piso_bit_cnt #(
  parameter int CW   = 3,
  parameter int LAST = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CW'(LAST));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready input and registered sdo/done.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdo,
  output logic             sdo_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             sdo_q, sdo_d;
  logic             done_q, done_d;
  logic [CW-1:0]    bit_cnt;
  logic             bit_tc;
  logic             gap_tc;
  logic             tap;

`ifdef PISO_PARITY_EN
  logic par_q, par_d;
`endif

  piso_bit_cnt #(.CW(CW), .LAST(WIDTH-1)) u_bit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (state_q != S_SHIFT),
    .en_i    (state_q == S_SHIFT),
    .cnt_o   (bit_cnt),
    .tc_o    (bit_tc)
  );

  generate
    if (GAP > 0) begin : g_gap
      logic [cnt_w(GAP+1)-1:0] gap_cnt_unused;
      piso_bit_cnt #(.CW(cnt_w(GAP+1)), .LAST(GAP-1)) u_gap_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (state_q != S_GAP),
        .en_i    (state_q == S_GAP),
        .cnt_o   (gap_cnt_unused),
        .tc_o    (gap_tc)
      );
    end else begin : g_no_gap
      assign gap_tc = 1'b1;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    case (state_q)
      S_IDLE: begin
        if (din_valid) begin
          state_d = S_SHIFT;
          sr_d    = din;
        end
      end
      S_SHIFT: begin
        sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
        if (bit_tc) begin
`ifdef PISO_PARITY_EN
          state_d = S_PARITY;
`else
          if (GAP > 0) state_d = S_GAP;
          else         state_d = S_IDLE;
`endif
        end
      end
      S_PARITY: begin
        if (GAP > 0) state_d = S_GAP;
        else         state_d = S_IDLE;
      end
      S_GAP: begin
        if (gap_tc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // sdo/done are computed one cycle ahead from the next state so they leave flops.
  always_comb begin
    tap    = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
    sdo_d  = 1'b0;
    done_d = 1'b0;
    if (state_d == S_SHIFT) sdo_d = tap;
`ifdef PISO_PARITY_EN
    par_d = (state_q == S_IDLE && din_valid) ? even_par(64'(din)) : par_q;
    if (state_d == S_PARITY) begin
      sdo_d  = par_q;
      done_d = 1'b1;
    end
`else
    done_d = (state_q == S_SHIFT) && (bit_cnt == CW'(WIDTH-2));
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      sdo_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      sdo_q   <= sdo_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign sdo       = sdo_q;
  assign done      = done_q;
  assign sdo_en    = (state_q == S_SHIFT) || (state_q == S_PARITY);
  assign busy      = (state_q != S_IDLE);
  assign din_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: default instance (MSB first, no gap)
// plus a GAP=2, LSB-first instance, both checked against a frame-level model.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, sdo, sdo_en, busy, done;
  logic [W-1:0] din2 = '0;
  logic         din_valid2 = 1'b0;
  logic         din_ready2, sdo2, sdo_en2, busy2, done2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sdo(sdo), .sdo_en(sdo_en), .busy(busy), .done(done)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(2)) u_dut_gap (
    .clk(clk), .reset_n(reset_n), .din(din2), .din_valid(din_valid2),
    .din_ready(din_ready2), .sdo(sdo2), .sdo_en(sdo_en2), .busy(busy2), .done(done2)
  );

  // Frame as transmitted: data bits in wire order, then even parity of the word.
  function automatic logic [W:0] frame_of(input logic [W-1:0] w, input bit msb);
    logic [W:0] fr;
    logic       p;
    p = 1'b0;
    for (int i = 0; i < W; i++) begin
      fr[i] = msb ? w[W-1-i] : w[i];
      p     = p ^ w[i];
    end
    fr[W] = p;
    return fr;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    din_valid = 1'b1;
    din       = 8'hA5;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (sdo !== 1'b0 || sdo_en !== 1'b0 || din_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cyc%0d got sdo=%b en=%b rdy=%b busy=%b done=%b exp 0 0 1 0 0",
                 c, sdo, sdo_en, din_ready, busy, done);
      end
      n_checks++;
      if (sdo_en2 !== 1'b0 || din_ready2 !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_gapdut cyc%0d got en=%b rdy=%b exp 0 1", c, sdo_en2, din_ready2);
      end
    end
    din_valid = 1'b0;
    reset_n   = 1'b1;
    tick();
    n_checks++;
    if (sdo_en !== 1'b0 || din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release got en=%b rdy=%b exp 0 1", sdo_en, din_ready);
    end
  endtask

  task automatic test_frame(input logic [W-1:0] w, input string name);
    logic [W:0]   fr;
    logic [W-1:0] sipo;
    int           guard;
    fr    = frame_of(w, 1'b1);
    sipo  = '0;
    guard = 0;
    while (din_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    n_checks++;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_timeout got rdy=%b exp 1", name, din_ready);
    end
    din       = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din       = ~w;
    for (int i = 0; i < FL; i++) begin
      n_checks++;
      if (sdo_en !== 1'b1 || sdo !== fr[i] || done !== (i == FL-1) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_bit%0d got en=%b sdo=%b done=%b busy=%b exp en=1 sdo=%b done=%b busy=1",
                 name, i, sdo_en, sdo, done, busy, fr[i], (i == FL-1));
      end
      if (i < W) sipo = {sipo[W-2:0], sdo};
      tick();
    end
    n_checks++;
    if (sdo_en !== 1'b0 || sdo !== 1'b0 || done !== 1'b0 || din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_after got en=%b sdo=%b done=%b rdy=%b exp 0 0 0 1",
               name, sdo_en, sdo, done, din_ready);
    end
    n_checks++;
    if (sipo !== w) begin
      n_fail++;
      $display("FAIL %s_sipo got %h exp %h", name, sipo, w);
    end
  endtask

  task automatic test_single();
    logic [W:0] lit;
    lit = frame_of(8'hA5, 1'b1);
    n_checks++;
    if (lit[W-1:0] !== 8'b10100101) begin
      n_fail++;
      $display("FAIL model_a5 got %b exp 10100101", lit[W-1:0]);
    end
    test_frame(8'hA5, "single_a5");
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    int           idle;
    for (int k = 0; k < 16; k++) begin
      w    = W'($urandom);
      idle = $urandom_range(0, 3);
      for (int j = 0; j < idle; j++) tick();
      test_frame(w, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] fa, fb;
    fa = frame_of(8'hFF, 1'b1);
    fb = frame_of(8'h01, 1'b1);
    din       = 8'hFF;
    din_valid = 1'b1;
    tick();
    din = 8'h01;
    for (int i = 0; i < FL; i++) begin
      n_checks++;
      if (sdo_en !== 1'b1 || sdo !== fa[i]) begin
        n_fail++;
        $display("FAIL b2b_ff_bit%0d got en=%b sdo=%b exp en=1 sdo=%b", i, sdo_en, sdo, fa[i]);
      end
      tick();
    end
    n_checks++;
    if (sdo_en !== 1'b0 || din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle got en=%b rdy=%b exp 0 1", sdo_en, din_ready);
    end
    tick();
    for (int i = 0; i < FL; i++) begin
      n_checks++;
      if (sdo_en !== 1'b1 || sdo !== fb[i] || done !== (i == FL-1)) begin
        n_fail++;
        $display("FAIL b2b_01_bit%0d got en=%b sdo=%b done=%b exp en=1 sdo=%b done=%b",
                 i, sdo_en, sdo, done, fb[i], (i == FL-1));
      end
      if (i == FL-1) din_valid = 1'b0;
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (sdo_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_no_extra cyc%0d got en=%b busy=%b exp 0 0", c, sdo_en, busy);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [W:0] fr;
    fr        = frame_of(8'hF0, 1'b1);
    din       = 8'hF0;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (sdo_en !== 1'b1 || sdo !== fr[i]) begin
        n_fail++;
        $display("FAIL rstmid_bit%0d got en=%b sdo=%b exp en=1 sdo=%b", i, sdo_en, sdo, fr[i]);
      end
      tick();
    end
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (sdo !== 1'b0 || sdo_en !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_abort got sdo=%b en=%b busy=%b rdy=%b done=%b exp 0 0 0 1 0",
               sdo, sdo_en, busy, din_ready, done);
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (sdo_en !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_partial got en=%b done=%b exp 0 0", sdo_en, done);
    end
    test_frame(8'h3C, "rstmid_3c");
  endtask

  task automatic test_gap();
    logic [W:0] fr;
    fr         = frame_of(8'h81, 1'b0);
    din2       = 8'h81;
    din_valid2 = 1'b1;
    tick();
    din_valid2 = 1'b0;
    for (int i = 0; i < FL; i++) begin
      n_checks++;
      if (sdo_en2 !== 1'b1 || sdo2 !== fr[i] || done2 !== (i == FL-1)) begin
        n_fail++;
        $display("FAIL gap_bit%0d got en=%b sdo=%b done=%b exp en=1 sdo=%b done=%b",
                 i, sdo_en2, sdo2, done2, fr[i], (i == FL-1));
      end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (sdo_en2 !== 1'b0 || sdo2 !== 1'b0 || busy2 !== 1'b1 || din_ready2 !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_idle cyc%0d got en=%b sdo=%b busy=%b rdy=%b exp 0 0 1 0",
                 c, sdo_en2, sdo2, busy2, din_ready2);
      end
      tick();
    end
    n_checks++;
    if (din_ready2 !== 1'b1 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_ready got rdy=%b busy=%b exp 1 0", din_ready2, busy2);
    end
  endtask

  task automatic test_parity();
    test_frame(8'h07, "parity_07");
    test_frame(8'h03, "parity_03");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_gap();
    test_parity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
